// File: rtl/fp_division_seq.sv
// Purpose: iterative IEEE-754 double divider C = A / B (radix-2 restoring, truncating, FTZ).
// Latency: special operands 1 cycle (done on the accept edge); normal operands 55 cycles.
// Backpressure: none; start is only taken while idle, and a start seen while busy is dropped.
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   start       - request; sampled only while idle (including the done cycle)
//   A, B        - dividend / divisor, captured on the accepted start
//   C           - registered quotient, held until the next completion
//   busy        - operation in flight (state != IDLE)
//   done        - one-cycle pulse, C is new in that cycle
module fp_division_seq #(
  parameter int MANT_W = 52,
  parameter int EXP_W  = 11,
  parameter int BIAS   = 1023,
  parameter int ITER   = MANT_W + 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [EXP_W+MANT_W:0]     A,
  input  logic [EXP_W+MANT_W:0]     B,
  output logic [EXP_W+MANT_W:0]     C,
  output logic                      busy,
  output logic                      done
);

  localparam int W  = 1 + EXP_W + MANT_W;
  localparam int CW = $clog2(ITER);
  localparam int EW = EXP_W + 2;   // signed headroom for eA - eB + BIAS

  typedef enum logic [1:0] {IDLE, CALC, NORM} state_t;

  state_t              state;
  logic                s_q;
  logic [EXP_W-1:0]    ea_q, eb_q;
  logic [MANT_W:0]     bm_q;
  logic [MANT_W+2:0]   r_q;
  logic [ITER-1:0]     q_q;
  logic [CW-1:0]       cnt_q;

  // operand classification on the live inputs (equal to the captured values at the accept edge)
  logic [EXP_W-1:0]  ea_in, eb_in;
  logic [MANT_W-1:0] fa_in, fb_in;
  logic              s_in, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;
  logic [W-1:0]      spec_c;

  assign ea_in  = A[W-2:MANT_W];
  assign eb_in  = B[W-2:MANT_W];
  assign fa_in  = A[MANT_W-1:0];
  assign fb_in  = B[MANT_W-1:0];
  assign s_in   = A[W-1] ^ B[W-1];
  assign a_zero = (ea_in == '0);
  assign b_zero = (eb_in == '0);
  assign a_inf  = (&ea_in) && (fa_in == '0);
  assign b_inf  = (&eb_in) && (fb_in == '0);
  assign a_nan  = (&ea_in) && (fa_in != '0);
  assign b_nan  = (&eb_in) && (fb_in != '0);
  assign special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

  always_comb begin
    spec_c = '0;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero))
      spec_c = {s_in, {EXP_W{1'b1}}, MANT_W'(1)};
    else if (a_inf || b_zero)
      spec_c = {s_in, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    else
      spec_c = '0;   // A zero or B inf
  end

  // restoring step: remainder always stays below 2*bm, so the shifted value fits
  logic [MANT_W+2:0] bm_ext, r_sub;
  logic              ge;
  assign bm_ext = {2'b00, bm_q};
  assign ge     = (r_q >= bm_ext);
  assign r_sub  = r_q - bm_ext;

  // pack: quotient lies in [0.5,2); a leading zero costs one exponent step
  logic [EW-1:0]     e;
  logic [MANT_W-1:0] frac;
  logic              ovf, unf;
  logic [W-1:0]      norm_c;

  always_comb begin
    e = {2'b00, ea_q} - {2'b00, eb_q} + EW'(BIAS) - (q_q[ITER-1] ? EW'(0) : EW'(1));
    frac = q_q[ITER-1] ? q_q[ITER-2:1] : q_q[ITER-3:0];
    // e is two's complement in EW bits; top bit set means negative
    ovf = !e[EW-1] && (e[EW-2] || (&e[EXP_W-1:0]));
    unf = e[EW-1] || (e == '0);
    if (ovf)
      norm_c = {s_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    else if (unf)
      norm_c = '0;
    else
      norm_c = {s_q, e[EXP_W-1:0], frac};
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      C     <= '0;
      done  <= 1'b0;
      s_q   <= 1'b0;
      ea_q  <= '0;
      eb_q  <= '0;
      bm_q  <= '0;
      r_q   <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (special) begin
              C    <= spec_c;
              done <= 1'b1;
            end else begin
              s_q   <= s_in;
              ea_q  <= ea_in;
              eb_q  <= eb_in;
              bm_q  <= {1'b1, fb_in};
              r_q   <= {2'b00, 1'b1, fa_in};
              q_q   <= '0;
              cnt_q <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          r_q   <= (ge ? r_sub : r_q) << 1;
          q_q   <= {q_q[ITER-2:0], ge};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(ITER - 1))
            state <= NORM;
        end
        NORM: begin
          C     <= norm_c;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
